// File: rtl/riscv_io_pkg.sv
// riscv_io_pkg: shared IO address map, status bit positions and UART TX FSM states.
package riscv_io_pkg;
  localparam logic [31:0] UART_TX_ADDR = 32'h8000_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h8000_0004;
  localparam int STAT_SHIFTING = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVERFLOW = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/riscv_sync_fifo.sv
// riscv_sync_fifo: single-clock FIFO; full/empty come from pre-edge count, so a push while full is dropped.
module riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/riscv_uart_tx.sv
// riscv_uart_tx: memory-mapped 8N1 console transmitter with byte FIFO and pollable status register.
module riscv_uart_tx
  import riscv_io_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          DEPTH = 4,
  parameter logic [31:0] BASE_ADDR = UART_TX_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        busy
);
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  tx_state_t state;
  logic [7:0] shift, dout;
  logic [2:0] bit_cnt;
  logic [BW-1:0] baud;
  logic overflow, full, empty, wr_tx, wr_stat, pop, bit_end, unused_wd;
  assign wr_tx = we && a == BASE_ADDR;
  assign wr_stat = we && a == STAT_ADDR;
  assign pop = state == IDLE && !empty;
  assign bit_end = baud == BAUD_MAX;
  assign busy = state != IDLE || !empty;
  assign unused_wd = ^wd[31:8];
  riscv_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(wr_tx), .pop(pop),
    .din(wd[7:0]), .dout(dout), .full(full), .empty(empty)
  );
  always_comb begin
    rd = '0;
    if (a == STAT_ADDR) begin
      rd[STAT_OVERFLOW] = overflow;
      rd[STAT_EMPTY] = empty;
      rd[STAT_FULL] = full;
      rd[STAT_SHIFTING] = state != IDLE;
    end
  end
  // tx is loaded on each transition so it always reflects the state being entered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      tx <= 1'b1;
      shift <= '0;
      bit_cnt <= '0;
      baud <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_tx && full) overflow <= 1'b1;
      else if (wr_stat && wd[3]) overflow <= 1'b0;
      if (state != IDLE) baud <= bit_end ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (!empty) begin
          shift <= dout;
          bit_cnt <= '0;
          baud <= '0;
          tx <= 1'b0;
          state <= START;
        end
        START: if (bit_end) begin
          tx <= shift[0];
          state <= DATA;
        end
        DATA: if (bit_end) begin
          shift <= shift >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          tx <= bit_cnt == 3'd7 ? 1'b1 : shift[1];
          state <= bit_cnt == 3'd7 ? STOP : DATA;
        end
        STOP: if (bit_end) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_riscv_uart_tx.sv
// tb_riscv_uart_tx: scoreboard bench; stores queue expected frames, a monitor decodes tx and compares.
module tb_riscv_uart_tx;
  localparam logic [31:0] DATA_A = 32'h8000_0000;
  localparam logic [31:0] STAT_A = 32'h8000_0004;
  logic clk = 0, reset = 1, we = 0;
  logic [31:0] a = 0, wd = 0;
  logic [31:0] rd;
  logic tx, busy;
  int cyc = 0, checks = 0, errors = 0;
  bit mon_en = 1, in_frame = 0;
  typedef struct {logic [7:0] data; int start;} exp_t;
  exp_t q[$];

  riscv_uart_tx #(.CLKS_PER_BIT(4), .DEPTH(4), .BASE_ADDR(32'h8000_0000)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, output int c);
    we = 1; a = addr; wd = data;
    @(posedge clk); #1;
    c = cyc; we = 0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((q.size() != 0 || in_frame) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || in_frame) begin
      checks++; errors++;
      $display("FAIL wait_idle timeout: %0d frames pending after %0d cycles", q.size(), limit);
    end
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    logic [9:0] fr;
    logic act;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected frame: tx low at cycle %0d with no byte queued", cyc);
          repeat (40) @(negedge clk);
        end else begin
          e = q.pop_front();
          in_frame = 1;
          check($sformatf("frame %h start cycle", e.data), cyc, e.start);
          fr = {1'b1, e.data, 1'b0};
          for (int b = 0; b < 10; b++) begin
            act = fr[b];
            for (int s = 0; s < 4; s++) begin
              if (b != 0 || s != 0) @(negedge clk);
              if (tx !== fr[b]) act = tx;
            end
            check($sformatf("frame %h bit %0d", e.data, b), act, fr[b]);
          end
          in_frame = 0;
        end
      end
    end
  end

  initial begin
    int c, c0, d;
    logic [7:0] b4 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    // idle after reset
    @(negedge clk);
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    a = STAT_A; #1 check("reset status", rd, 32'h4);
    a = DATA_A; #1 check("data reg read", rd, 32'h0);
    @(posedge clk); #1;
    // single byte
    wr(DATA_A, 32'h56, c);
    q.push_back('{8'h56, c + 1});
    wait_idle(100);
    check("busy after frame", busy, 0);
    check("tx after frame", tx, 1);
    // back-to-back bytes, one idle cycle between frames
    wr(DATA_A, 32'h56, c);
    q.push_back('{8'h56, c + 1});
    wr(DATA_A, 32'h41, d);
    q.push_back('{8'h41, c + 42});
    wait_idle(200);
    check("busy after pair", busy, 0);
    // overflow: five accepted, sixth dropped
    for (int i = 0; i < 6; i++) begin
      wr(DATA_A, {24'hFFFFFF, b4[i]}, c);
      if (i == 0) c0 = c;
      if (i < 5) q.push_back('{b4[i], c0 + 1 + 41 * i});
    end
    a = STAT_A; #1 check("status overflow+full", rd, 32'hB);
    wr(STAT_A, 32'h8, c);
    a = STAT_A; #1 check("status overflow cleared", rd, 32'h3);
    wait_idle(600);
    a = STAT_A; #1 check("status after burst", rd, 32'h4);
    // reset mid-frame
    mon_en = 0;
    wr(DATA_A, 32'hA5, c);
    repeat (10) @(posedge clk);
    #1 check("busy in DATA", busy, 1);
    #1 reset = 1;
    #1 check("tx on async reset", tx, 1);
    a = STAT_A; #1 check("status in reset", rd, 32'h4);
    check("busy in reset", busy, 0);
    @(posedge clk); #1 reset = 0;
    mon_en = 1;
    repeat (60) @(negedge clk);
    check("tx after reset", tx, 1);
    check("busy after reset", busy, 0);
    @(posedge clk); #1;
    // unmapped addresses
    wr(32'h8000_0008, 32'h55, c);
    wr(32'h0000_0000, 32'h55, c);
    a = 32'h8000_0008; #1 check("rd unmapped 8", rd, 32'h0);
    a = 32'h0000_0000; #1 check("rd unmapped 0", rd, 32'h0);
    a = STAT_A; #1 check("status after unmapped", rd, 32'h4);
    repeat (30) @(negedge clk);
    check("busy after unmapped", busy, 0);
    check("scoreboard drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_uart_tx.md
# riscv_uart_tx

Memory-mapped console transmitter at the processor's IO window (0x8000_0000). It accepts byte stores from the data-memory port, buffers them in a small FIFO, and serializes each byte as 8N1 UART frames on one output pin. A status register lets firmware poll for space and busy state before storing. It is the receiving end of the program's store-to-IO path (`sw x2, 0(x1)` with x1 = 0x8000_0000).

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `DEPTH`, 4: FIFO entries; must be a power of 2, ≥ 2.
- `BASE_ADDR`, 32'h8000_0000: TX data register address. The status register sits at BASE_ADDR+4.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `we` in 1: store strobe from the memory stage.
- `a` in 32: byte address from the memory stage.
- `wd` in 32: store data. Only `wd[7:0]` is used for TX data.
- `rd` out 32: combinational read data for status.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high while a frame is in progress or the FIFO is non-empty.

## Operation
- Address decode uses full 32-bit compare. Any other address is ignored: no write effect, and `rd` = 0.
- A write to BASE_ADDR pushes `wd[7:0]` if the FIFO is not full. If full, the byte is dropped and sticky `overflow` is set.
- A write to BASE_ADDR+4 with `wd[3]`=1 clears `overflow`.
- Status read at BASE_ADDR+4 returns `rd` = {28'b0, overflow, fifo_empty, fifo_full, shifting}. `shifting` means the FSM is not IDLE.
- A read at BASE_ADDR returns 0. TX data is write-only.
- Full is evaluated on pre-edge state. A push while full is rejected even if a pop happens on the same edge.
- Push and pop on the same edge when not full: both take effect and the count is unchanged.
- FSM states:
  - IDLE: `tx`=1. If FIFO non-empty: pop into shift register, clear bit counter and baud counter, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back bytes: IDLE lasts exactly one cycle between the last STOP cycle and the next START.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps when the bit ends. The bit counter is 3 bits.
- FIFO pointers are log2(DEPTH) bits wide, wrapping. The count is log2(DEPTH)+1 bits.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `rd`=0.
  - FSM=IDLE, FIFO empty, `overflow`=0, all counters 0.
- Reset asserted mid-frame: `tx` goes high immediately (asynchronous). The queued bytes and the partial frame are discarded.
- Store latency:
  - Write accepted at edge N.
  - The byte is popped at edge N+1.
  - `tx` falls after edge N+1.
- Frame length: exactly 10×CLKS_PER_BIT cycles of START+DATA+STOP.
- `busy` rises after edge N and falls after the edge that leaves STOP when the FIFO is empty.
- `tx` is registered and glitch-free. `rd` is combinational from `a` and the current state.

## Structure
- Shared package `riscv_io_pkg`:
  - IO address constants: UART_TX_ADDR, UART_STAT_ADDR.
  - Status bit index constants.
  - FSM state enum {IDLE, START, DATA, STOP}.
- Sub-module `riscv_sync_fifo`:
  - Parameterized width and depth.
  - push/pop/full/empty interface, async active-high reset.
  - Reusable for a later RX block.

## Test plan
Bench uses CLKS_PER_BIT=4, DEPTH=4.
1. Reset, then check idle outputs, no stimulus → `tx`=1, `busy`=0, read BASE+4 → `rd`=32'h4.
2. Store 0x56 to 0x8000_0000 → starting one cycle later, `tx` = 0,0,1,1,0,1,0,1,0,1, each level held 4 cycles (40 cycles total). Then `busy`=0.
3. Store 0x56 then 0x41 on consecutive cycles → two frames separated by exactly one idle-high cycle. The second frame's data bits are 1,0,0,0,0,0,1,0.
4. Store 6 bytes in 6 consecutive cycles → 5 accepted: 1 popped into the shifter plus 4 in the FIFO. The 6th is dropped. Status shows overflow=1 and full=1. Write 32'h8 to 0x8000_0004 → overflow=0.
5. Assert `reset` during the DATA state of a frame → `tx`=1 within the same cycle. FIFO empty. No further frame is emitted.
6. Stores to 0x8000_0008 and 0x0000_0000 → no frame, FIFO stays empty, `rd`=0 at those addresses.
